// File: rtl/drum_voice_mixer.sv
// Drum voice mixer: per sample tick, fetches one ROM sample per voice,
// sums the active ones as signed values, re-biases to midscale, saturates,
// and registers the result as the unsigned PWM duty value.

// Per-voice playback state: the play flag and the read offset into the voice's ROM region.
module drum_voice_lane #(
    parameter int SAMPLE_AW = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,   // (re)trigger: restart from offset 0
    input  logic                 adv_i,     // this voice's sample was consumed this cycle
    output logic                 active_o,
    output logic [SAMPLE_AW-1:0] offset_o
);
    logic                 active_q, active_d;
    logic [SAMPLE_AW-1:0] offset_q, offset_d;

    // Next state: restart on trigger, else step and stop after the last word.
    always_comb begin
        active_d = active_q;
        offset_d = offset_q;
        if (start_i) begin
            active_d = 1'b1;
            offset_d = '0;
        end else if (adv_i && active_q) begin
            if (offset_q == '1) begin
                offset_d = '0;
                active_d = 1'b0;
            end else begin
                offset_d = offset_q + 1'b1;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            offset_q <= '0;
        end else begin
            active_q <= active_d;
            offset_q <= offset_d;
        end
    end

    assign active_o = active_q;
    assign offset_o = offset_q;
endmodule

module drum_voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_AW  = 12,
    parameter int SAMPLE_W   = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    sample_tick,
    input  logic [NUM_VOICES-1:0]                   trig,
    output logic                                    rom_en,
    output logic [$clog2(NUM_VOICES)+SAMPLE_AW-1:0] rom_addr,
    input  logic [SAMPLE_W-1:0]                     rom_data,
    output logic [SAMPLE_W-1:0]                     duty_cycle,
    output logic                                    sample_valid,
    output logic [NUM_VOICES-1:0]                   active,
    output logic                                    busy,
    output logic                                    overrun
);
    localparam int VW    = $clog2(NUM_VOICES);
    localparam int ACC_W = SAMPLE_W + VW;   // N signed samples cannot overflow this
    localparam logic signed [ACC_W:0] MID  = (ACC_W+1)'(2**(SAMPLE_W-1));
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**SAMPLE_W - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                          state_q, state_d;
    logic [VW-1:0]                   idx_q, idx_d;       // voice being addressed
    logic                            rd_vld_q, rd_vld_d; // rom_data valid this cycle
    logic [VW-1:0]                   rd_idx_q, rd_idx_d; // voice that rom_data belongs to
    logic signed [ACC_W-1:0]         acc_q, acc_d;
    logic [NUM_VOICES-1:0]           pend_q, pend_d;
    logic [SAMPLE_W-1:0]             duty_q, duty_d;
    logic                            overrun_q, overrun_d;
    logic signed [ACC_W:0]           biased;

    logic [NUM_VOICES-1:0]                 start, adv, active_w;
    logic [NUM_VOICES-1:0][SAMPLE_AW-1:0]  off;

    // A tick in IDLE launches every pending voice, including same-cycle triggers.
    always_comb begin
        start = '0;
        if (state_q == IDLE && sample_tick) start = pend_q | trig;
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_lane
        assign adv[v] = rd_vld_q && (rd_idx_q == VW'(v));
        drum_voice_lane #(.SAMPLE_AW(SAMPLE_AW)) u_lane (
            .clk_i    (clk),
            .rst_i    (rst),
            .start_i  (start[v]),
            .adv_i    (adv[v]),
            .active_o (active_w[v]),
            .offset_o (off[v])
        );
    end

    // Sequencer next state, accumulation of returning ROM data, and saturation.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_vld_d  = 1'b0;
        rd_idx_d  = idx_q;
        acc_d     = acc_q;
        pend_d    = pend_q | trig;
        duty_d    = duty_q;
        overrun_d = overrun_q | (sample_tick && state_q != IDLE);

        // Data lands one cycle after its fetch; inactive voices contribute nothing.
        if (rd_vld_q && active_w[rd_idx_q])
            acc_d = acc_q + $signed({{VW{rom_data[SAMPLE_W-1]}}, rom_data});

        biased = $signed({acc_d[ACC_W-1], acc_d}) + MID;

        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    pend_d  = '0;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rd_vld_d = 1'b1;
                idx_d    = idx_q + 1'b1;
                if (idx_q == VW'(NUM_VOICES-1)) state_d = DRAIN;
            end
            DRAIN: begin
                // acc_d now includes the last voice, so the duty lands in DONE.
                if (biased < 0)         duty_d = '0;
                else if (biased > MAXV) duty_d = '1;
                else                    duty_d = biased[SAMPLE_W-1:0];
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers with synchronous reset; duty resets to midscale silence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_idx_q  <= '0;
            acc_q     <= '0;
            pend_q    <= '0;
            duty_q    <= SAMPLE_W'(2**(SAMPLE_W-1));
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rd_vld_q  <= rd_vld_d;
            rd_idx_q  <= rd_idx_d;
            acc_q     <= acc_d;
            pend_q    <= pend_d;
            duty_q    <= duty_d;
            overrun_q <= overrun_d;
        end
    end

    assign rom_en       = (state_q == FETCH);
    assign rom_addr     = (state_q == FETCH) ? {idx_q, off[idx_q]} : '0;
    assign duty_cycle   = duty_q;
    assign sample_valid = (state_q == DONE);
    assign active       = active_w;
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;
endmodule

// File: tb/tb_drum_voice_mixer.sv
// Directed bench for drum_voice_mixer (4 voices, 4-word samples, 8-bit).
// Expected duty values are pushed at each tick; a monitor pops them on sample_valid.
module tb_drum_voice_mixer;
    logic       clk = 1'b0;
    logic       rst;
    logic       sample_tick;
    logic [3:0] trig;
    logic       rom_en;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] duty_cycle;
    logic       sample_valid;
    logic [3:0] active;
    logic       busy;
    logic       overrun;

    drum_voice_mixer #(.NUM_VOICES(4), .SAMPLE_AW(2), .SAMPLE_W(8)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .trig(trig),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .duty_cycle(duty_cycle), .sample_valid(sample_valid), .active(active),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM model: 4 voices x 4 words.
    logic [7:0] mem [16];
    always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

    typedef struct { logic [7:0] duty; int cyc; } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic fill(input int v, input logic [7:0] val);
        for (int k = 0; k < 4; k++) mem[v*4+k] = val;
    endtask

    // Monitor: every sample_valid must match the oldest expectation, at tick+6.
    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid: got duty %0d expected no pulse", duty_cycle);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("duty", 32'(duty_cycle), 32'(e.duty));
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic pulse_trig(input logic [3:0] m);
        @(posedge clk); #1 trig = m;
        @(posedge clk); #1 trig = '0;
    endtask

    // Issue a tick (with same-cycle trig tm), check the 4 fetch addresses against
    // exp_off (2 bits per voice), optionally pulse mid_trig in the first FETCH cycle.
    task automatic tick(input logic [3:0] tm, input logic [7:0] exp, input logic [7:0] exp_off,
                        input logic [3:0] mid_trig);
        exp_t e;
        @(posedge clk); #1;
        sample_tick = 1'b1; trig = tm;
        e.duty = exp; e.cyc = cyc + 6;
        q.push_back(e);
        @(posedge clk); #1;
        sample_tick = 1'b0; trig = mid_trig;
        for (int i = 0; i < 4; i++) begin
            chk("rom_en_fetch", 32'(rom_en), 32'd1);
            chk("rom_addr", 32'(rom_addr), 32'({i[1:0], exp_off[i*2 +: 2]}));
            @(posedge clk); #1;
            trig = '0;
        end
        chk("rom_en_drain", 32'(rom_en), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; sample_tick = 1'b0; trig = '0;
        for (int k = 0; k < 16; k++) mem[k] = 8'd50;
        for (int k = 0; k < 4; k++) mem[4+k] = 8'(k);   // voice 1 ramp
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_duty", 32'(duty_cycle), 32'd128);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);

        // Ramp on voice 1, runs off the end on the 4th tick; other voices idle (ROM=50).
        pulse_trig(4'b0010);
        tick(4'h0, 8'd128, 8'h00, 4'h0);
        tick(4'h0, 8'd129, 8'h04, 4'h0);
        tick(4'h0, 8'd130, 8'h08, 4'h0);
        chk("active_ramp", 32'(active), 32'h2);
        tick(4'h0, 8'd131, 8'h0C, 4'h0);
        chk("active_end", 32'(active), 32'h0);
        tick(4'h0, 8'd128, 8'h00, 4'h0);

        // Saturation; trig in the tick cycle is included.
        for (int v = 0; v < 4; v++) fill(v, 8'd100);
        tick(4'hF, 8'd255, 8'h00, 4'h0);
        for (int v = 0; v < 4; v++) fill(v, 8'h9C);     // -100
        tick(4'h0, 8'd0, 8'h55, 4'h0);
        fill(0, 8'd100); fill(1, 8'h9C); fill(2, 8'd0); fill(3, 8'd0);
        tick(4'h0, 8'd128, 8'hAA, 4'h0);
        fill(0, 8'd10); fill(1, 8'd0);
        tick(4'h0, 8'd138, 8'hFF, 4'h0);
        chk("active_sat_end", 32'(active), 32'h0);

        // Retrigger restarts at offset 0; trig during FETCH waits for the next tick.
        fill(0, 8'd5); fill(1, 8'd0); fill(2, 8'd0);
        for (int k = 0; k < 4; k++) mem[12+k] = 8'(10*k);
        tick(4'h8, 8'd128, 8'h00, 4'h0);
        tick(4'h0, 8'd138, 8'h40, 4'h0);
        pulse_trig(4'b1000);
        tick(4'h0, 8'd128, 8'h00, 4'h0);
        tick(4'h0, 8'd138, 8'h40, 4'b0001);
        tick(4'h0, 8'd153, 8'h80, 4'h0);

        // Overrun: second tick 3 cycles later is dropped.
        chk("overrun_pre", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        sample_tick = 1'b1;
        q.push_back('{duty: 8'd163, cyc: cyc + 6});
        @(posedge clk); #1 sample_tick = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 sample_tick = 1'b1;
        chk("busy_at_2nd_tick", 32'(busy), 32'd1);
        @(posedge clk); #1 sample_tick = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("overrun_set", 32'(overrun), 32'd1);
        chk("active_after_ovr", 32'(active), 32'h1);
        tick(4'h0, 8'd133, 8'h02, 4'h0);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Reset in the middle of FETCH: no pulse, silence, normal tick afterwards.
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_duty", 32'(duty_cycle), 32'd128);
        chk("mid_rst_active", 32'(active), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        repeat (8) @(posedge clk);
        fill(2, 8'd7);
        tick(4'b0100, 8'd135, 8'h00, 4'h0);

        repeat (10) @(posedge clk);
        #1 chk("pending_expectations", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/drum_voice_mixer.md
Name: drum_voice_mixer

Overview:
- Sample-rate front end of the drum machine audio path. Sits directly upstream of the PWM output stage and produces its `duty_cycle` input.
- Plays up to NUM_VOICES one-shot drum samples stored in an external synchronous ROM, one region per voice.
- On each sample tick it fetches one sample per active voice, sums them as signed values and adds a midscale offset.
- It then saturates the result and registers it as the unsigned PWM duty value.

Parameters:
- NUM_VOICES, 4, number of drum voices/pads; must be a power of two ≥ 2.
- SAMPLE_AW, 12, per-voice sample offset width; each sample is 2**SAMPLE_AW words long.
- SAMPLE_W, 8, ROM sample width (signed two's complement); also the width of `duty_cycle`.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- sample_tick, in, 1, one-cycle pulse at the audio sample rate (PWM period wrap).
- trig, in, NUM_VOICES, one-cycle trigger pulse per voice (from pad debouncers).
- rom_en, out, 1, ROM read enable.
- rom_addr, out, $clog2(NUM_VOICES)+SAMPLE_AW, ROM address = {voice index, offset}.
- rom_data, in, SAMPLE_W, ROM read data, valid exactly 1 cycle after `rom_en`.
- duty_cycle, out, SAMPLE_W, unsigned duty value to the PWM stage.
- sample_valid, out, 1, one-cycle pulse when `duty_cycle` updates.
- active, out, NUM_VOICES, voice-playing flags.
- busy, out, 1, high while not IDLE.
- overrun, out, 1, sticky: a tick arrived while busy.

Behaviour:
- Reset values (`rst` sampled high at a clk edge):
  - `duty_cycle` = 2**(SAMPLE_W-1) (128, silence); `sample_valid`, `rom_en`, `busy`, `overrun` = 0.
  - `active` = 0; `rom_addr` = 0; all offsets and pending triggers = 0; FSM = IDLE.
- Reset mid-operation aborts the FSM with no `sample_valid` pulse.
- Trigger capture:
  - A `trig[v]` pulse sets `pending[v]` in any state.
  - A trigger on an already pending voice is idempotent.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - On `sample_tick`, every pending voice gets `active[v]` = 1 and offset[v] = 0 (retrigger restarts an already playing voice). Pending is cleared.
  - A `trig` asserted in the same cycle as the tick is included in this tick.
  - Accumulator cleared, index i = 0, go to FETCH.
- FETCH (N = NUM_VOICES cycles, tick in cycle T):
  - In cycle T+1+i: `rom_en` = 1, `rom_addr` = {i, offset[i]}, regardless of `active[i]`.
  - After voice N-1 go to DRAIN.
- Accumulate:
  - In cycle T+2+i, if voice i is active, sign-extend `rom_data` and add it to a signed accumulator of SAMPLE_W+$clog2(NUM_VOICES) bits (no overflow possible). Otherwise add 0.
  - Offset advance: if the voice is active, offset[i] increments. If offset[i] was 2**SAMPLE_AW-1, offset wraps to 0 and `active[i]` clears. The last sample is still included in this tick's sum.
- DRAIN: one cycle (T+N+1) consuming the data of voice N-1; `rom_en` = 0.
- DONE (cycle T+N+2):
  - `duty_cycle` = clamp(acc + 2**(SAMPLE_W-1), 0, 2**SAMPLE_W-1).
  - `sample_valid` = 1 for exactly this cycle; return to IDLE.
  - Total latency, tick to update: N+2 cycles.
- `duty_cycle` holds its value between updates, including while no voice is active (it then settles at 128 after the next tick).
- `busy` = 1 in FETCH, DRAIN and DONE.
  - A `sample_tick` while busy is dropped (no queueing) and sets `overrun` = 1 until reset.
  - Trigs received while busy remain pending for the next tick.
- `rom_en` is 0 outside FETCH.

Test Plan:
- Reset: assert `rst` 2 cycles mid-FETCH → `duty_cycle` = 128, `active` = 0, `sample_valid` never pulses, next tick behaves normally.
- Single voice, ROM voice 1 = ramp 0,1,2…: `trig[1]`, then ticks → `duty_cycle` = 128,129,130; `rom_addr` = {1,0},{1,1},{1,2}; `sample_valid` exactly 6 cycles after each tick (N=4).
- Saturation: voices 0–3 all hold +100 → 128+400 clamps to 255; all hold −100 → clamps to 0; voice 0 = +100 and voice 1 = −100 → 128.
- End of sample (SAMPLE_AW = 2 build): trig voice 2 → 4 ticks produce samples 0..3, `active[2]` clears on the 4th tick, 5th tick gives 128.
- Retrigger and concurrent events: trig voice 0 at offset 5 → next tick reads offset 0. Trig in the same cycle as tick → included in that tick's sum. Trig during FETCH → applied on the following tick.
- Overrun: tick at T and again at T+3 → second tick ignored, `overrun` = 1 and sticky, exactly one `sample_valid`.
